// File: rtl/audio_mixer_player.sv
// Multi-channel ROM clip player: per-channel IDLE/PLAY sequencers, saturating offset-binary mixer
// and a single-bit PWM speaker output.
module audio_mixer_player #(
  parameter int NUM_CH   = 3,
  parameter int ADDR_W   = 17,
  parameter int SAMPLE_W = 8,
  parameter int DIV_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            trig,
  input  logic [NUM_CH-1:0]            stop,
  input  logic [NUM_CH-1:0]            loop_en,
  input  logic                         mute,
  input  logic [NUM_CH*DIV_W-1:0]      rate_div,
  input  logic [NUM_CH*ADDR_W-1:0]     clip_len,
  output logic [NUM_CH*ADDR_W-1:0]     rom_addr,
  input  logic [NUM_CH*SAMPLE_W-1:0]   rom_data,
  output logic [NUM_CH-1:0]            busy,
  output logic [NUM_CH-1:0]            done,
  output logic [SAMPLE_W-1:0]          mix_sample,
  output logic                         audio
);

  localparam int SUM_W = SAMPLE_W + 3;
  localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'((1 << (SAMPLE_W-1)) - 1);
  localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(-(1 << (SAMPLE_W-1)));

  typedef enum logic {IDLE, PLAY} state_t;

  logic signed [SUM_W-1:0] centered [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr, addr_nxt, len;
    logic [DIV_W-1:0]    divcnt, div_nxt, rdiv;
    logic                done_r, done_nxt;
    logic                busy_d;
    logic [SAMPLE_W-1:0] smp;

    assign len  = clip_len[i*ADDR_W +: ADDR_W];
    assign rdiv = rate_div[i*DIV_W +: DIV_W];

    always_ff @(posedge clk) begin
      if (rst) begin
        state  <= IDLE;
        addr   <= '0;
        divcnt <= '0;
        done_r <= 1'b0;
        busy_d <= 1'b0;
        smp    <= MID;
      end else begin
        state  <= state_nxt;
        addr   <= addr_nxt;
        divcnt <= div_nxt;
        done_r <= done_nxt;
        busy_d <= (state == PLAY);
        smp    <= busy_d ? rom_data[i*SAMPLE_W +: SAMPLE_W] : MID;
      end
    end

    // stop has priority over trig; a zero-length trigger just parks the channel
    always_comb begin
      state_nxt = state;
      addr_nxt  = addr;
      div_nxt   = divcnt;
      done_nxt  = 1'b0;
      if (stop[i]) begin
        state_nxt = IDLE;
        addr_nxt  = '0;
        div_nxt   = '0;
      end else if (trig[i]) begin
        state_nxt = (len != '0) ? PLAY : IDLE;
        addr_nxt  = '0;
        div_nxt   = '0;
      end else if (state == PLAY) begin
        if (divcnt == rdiv) begin
          div_nxt = '0;
          if (addr == len - ADDR_W'(1)) begin
            addr_nxt = '0;
            if (!loop_en[i]) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            addr_nxt = addr + ADDR_W'(1);
          end
        end else begin
          div_nxt = divcnt + DIV_W'(1);
        end
      end
    end

    // offset-binary to two's complement is an MSB flip, then sign-extend
    assign centered[i] = {{3{~smp[SAMPLE_W-1]}}, ~smp[SAMPLE_W-1], smp[SAMPLE_W-2:0]};
    assign rom_addr[i*ADDR_W +: ADDR_W] = addr;
    assign busy[i] = (state == PLAY);
    assign done[i] = done_r;
  end

  logic signed [SUM_W-1:0] sum;
  logic [SAMPLE_W-1:0]     clamped;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = sum + centered[i];
    end
    if (sum > SUM_MAX) begin
      clamped = SUM_MAX[SAMPLE_W-1:0];
    end else if (sum < SUM_MIN) begin
      clamped = SUM_MIN[SAMPLE_W-1:0];
    end else begin
      clamped = sum[SAMPLE_W-1:0];
    end
  end

  logic [SAMPLE_W-1:0] pwm_cnt, duty;

  always_ff @(posedge clk) begin
    if (rst) begin
      mix_sample <= MID;
      pwm_cnt    <= '0;
      duty       <= '0;
      audio      <= 1'b0;
    end else begin
      mix_sample <= mute ? MID : {~clamped[SAMPLE_W-1], clamped[SAMPLE_W-2:0]};
      pwm_cnt    <= pwm_cnt + SAMPLE_W'(1);
      if (pwm_cnt == '0) begin
        duty <= mix_sample;
      end
      audio <= (pwm_cnt < duty);
    end
  end

endmodule

// File: tb/tb_audio_mixer_player.sv
// Scoreboard bench for audio_mixer_player: expected addresses, status bits and mix values are
// queued as stimulus is applied and popped as the DUT produces them.
module tb_audio_mixer_player;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  trig, stop, loop_en;
  logic        mute;
  logic [47:0] rate_div;
  logic [50:0] clip_len;
  logic [50:0] rom_addr;
  logic [23:0] rom_data;
  logic [2:0]  busy, done;
  logic [7:0]  mix_sample;
  logic        audio;

  logic [7:0]  rom_base [3];

  typedef struct packed {
    logic [16:0] addr;
    logic        busy;
    logic        done;
  } ch_exp_t;

  ch_exp_t    exp_ch  [$];
  logic [7:0] exp_mix [$];

  int n_checks = 0;
  int n_fail   = 0;

  audio_mixer_player dut (
    .clk        (clk),
    .rst        (rst),
    .trig       (trig),
    .stop       (stop),
    .loop_en    (loop_en),
    .mute       (mute),
    .rate_div   (rate_div),
    .clip_len   (clip_len),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .busy       (busy),
    .done       (done),
    .mix_sample (mix_sample),
    .audio      (audio)
  );

  always #5 clk = ~clk;

  // synchronous ROM model: data = per-channel base + low address byte
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      rom_data[i*8 +: 8] <= rom_base[i] + rom_addr[i*17 +: 8];
    end
  end

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_ch(input int ch, input int len, input int div, input bit lp);
    clip_len[ch*17 +: 17] = len[16:0];
    rate_div[ch*16 +: 16] = div[15:0];
    loop_en[ch]           = lp;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(2);
    n_checks++; if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_addr got %h exp 0", rom_addr); end
    n_checks++; if (busy !== 3'b000) begin n_fail++; $display("FAIL reset_busy got %b exp 000", busy); end
    n_checks++; if (done !== 3'b000) begin n_fail++; $display("FAIL reset_done got %b exp 000", done); end
    n_checks++; if (mix_sample !== 8'h80) begin n_fail++; $display("FAIL reset_mix got %h exp 80", mix_sample); end
    n_checks++; if (audio !== 1'b0) begin n_fail++; $display("FAIL reset_audio got %b exp 0", audio); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_oneshot;
    ch_exp_t e, got;
    set_ch(0, 4, 2, 1'b0);
    for (int k = 0; k < 12; k++) exp_ch.push_back('{addr: 17'(k / 3), busy: 1'b1, done: 1'b0});
    exp_ch.push_back('{addr: 17'd0, busy: 1'b0, done: 1'b1});
    exp_ch.push_back('{addr: 17'd0, busy: 1'b0, done: 1'b0});
    trig = 3'b001;
    tick();
    trig = 3'b000;
    while (exp_ch.size() > 0) begin
      e   = exp_ch.pop_front();
      got = '{addr: rom_addr[16:0], busy: busy[0], done: done[0]};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL oneshot_seq got addr=%0d busy=%b done=%b exp addr=%0d busy=%b done=%b",
                 got.addr, got.busy, got.done, e.addr, e.busy, e.done);
      end
      tick();
    end
  endtask

  task automatic test_loop;
    ch_exp_t e, got;
    set_ch(0, 4, 2, 1'b1);
    for (int k = 0; k < 19; k++) exp_ch.push_back('{addr: 17'((k / 3) % 4), busy: 1'b1, done: 1'b0});
    trig = 3'b001;
    tick();
    trig = 3'b000;
    for (int k = 0; k < 19; k++) begin
      e   = exp_ch.pop_front();
      got = '{addr: rom_addr[16:0], busy: busy[0], done: done[0]};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL loop_seq k=%0d got addr=%0d busy=%b done=%b exp addr=%0d busy=%b done=%b",
                 k, got.addr, got.busy, got.done, e.addr, e.busy, e.done);
      end
      if (k < 18) tick();
    end
    stop = 3'b001;
    tick();
    stop = 3'b000;
    n_checks++;
    if ({rom_addr[16:0], busy[0], done[0]} !== 19'd0) begin
      n_fail++; $display("FAIL loop_stop got addr=%0d busy=%b done=%b exp 0 0 0", rom_addr[16:0], busy[0], done[0]);
    end
    tick();
    n_checks++;
    if ({busy[0], done[0]} !== 2'b00) begin
      n_fail++; $display("FAIL loop_stop_after got busy=%b done=%b exp 0 0", busy[0], done[0]);
    end
  endtask

  task automatic test_trig_stop;
    tick(2);
    set_ch(0, 8, 0, 1'b0);
    trig = 3'b001; stop = 3'b001;
    tick();
    trig = 3'b000; stop = 3'b000;
    n_checks++;
    if (busy[0] !== 1'b0 || rom_addr[16:0] !== 17'd0) begin
      n_fail++; $display("FAIL trig_stop_same got busy=%b addr=%0d exp busy=0 addr=0", busy[0], rom_addr[16:0]);
    end
    tick();
    n_checks++; if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL trig_stop_hold got busy=%b exp 0", busy[0]); end
    trig = 3'b001;
    tick();
    trig = 3'b000;
    tick(3);
    n_checks++; if (rom_addr[16:0] !== 17'd3) begin n_fail++; $display("FAIL pre_retrig_addr got %0d exp 3", rom_addr[16:0]); end
    trig = 3'b001;
    tick();
    trig = 3'b000;
    n_checks++;
    if (rom_addr[16:0] !== 17'd0 || busy[0] !== 1'b1) begin
      n_fail++; $display("FAIL retrig_restart got addr=%0d busy=%b exp addr=0 busy=1", rom_addr[16:0], busy[0]);
    end
    tick();
    n_checks++; if (rom_addr[16:0] !== 17'd1) begin n_fail++; $display("FAIL retrig_next got %0d exp 1", rom_addr[16:0]); end
    stop = 3'b001;
    tick();
    stop = 3'b000;
    set_ch(1, 0, 0, 1'b0);
    trig = 3'b010;
    tick();
    trig = 3'b000;
    n_checks++;
    if (busy[1] !== 1'b0 || done[1] !== 1'b0) begin
      n_fail++; $display("FAIL zero_len_trig got busy=%b done=%b exp 0 0", busy[1], done[1]);
    end
    tick();
    n_checks++; if (busy[1] !== 1'b0) begin n_fail++; $display("FAIL zero_len_hold got busy=%b exp 0", busy[1]); end
  endtask

  task automatic test_latency;
    logic [7:0] e;
    tick(3);
    set_ch(0, 8, 0, 1'b1);
    rom_base[0] = 8'hA0;
    for (int j = 0; j < 3; j++) exp_mix.push_back(8'h80);
    for (int j = 0; j < 10; j++) exp_mix.push_back(8'hA0 + 8'(j % 8));
    trig = 3'b001;
    tick();
    trig = 3'b000;
    while (exp_mix.size() > 0) begin
      e = exp_mix.pop_front();
      n_checks++;
      if (mix_sample !== e) begin n_fail++; $display("FAIL latency_mix got %h exp %h", mix_sample, e); end
      tick();
    end
    stop = 3'b111;
    tick();
    stop = 3'b000;
  endtask

  task automatic test_mix;
    logic [7:0] b0 [6] = '{8'hFF, 8'h00, 8'hC0, 8'h90, 8'hC0, 8'hC0};
    logic [7:0] b1 [6] = '{8'hFF, 8'h00, 8'h40, 8'h90, 8'hC0, 8'hC0};
    logic [7:0] ex [6] = '{8'hFF, 8'h00, 8'h80, 8'hA0, 8'hB0, 8'h80};
    logic [7:0] e;
    tick(3);
    for (int c = 0; c < 3; c++) set_ch(c, 4, 16'hFFFF, 1'b1);
    rom_base[2] = 8'h30;
    trig = 3'b011;
    tick();
    trig = 3'b000;
    for (int p = 0; p < 6; p++) begin
      rom_base[0] = b0[p];
      rom_base[1] = b1[p];
      if (p == 4) begin
        trig = 3'b100;
        tick();
        trig = 3'b000;
      end
      mute = (p == 5);
      exp_mix.push_back(ex[p]);
      tick(4);
      e = exp_mix.pop_front();
      n_checks++;
      if (mix_sample !== e) begin n_fail++; $display("FAIL mix_pattern p=%0d got %h exp %h", p, mix_sample, e); end
    end
    mute = 1'b0;
    stop = 3'b111;
    tick();
    stop = 3'b000;
  endtask

  task automatic test_pwm;
    logic [7:0] bases [4] = '{8'h40, 8'h00, 8'hFF, 8'hFF};
    int         expc  [4] = '{64, 0, 255, 128};
    int         cnt;
    tick(3);
    set_ch(0, 4, 16'hFFFF, 1'b1);
    trig = 3'b001;
    tick();
    trig = 3'b000;
    for (int p = 0; p < 4; p++) begin
      rom_base[0] = bases[p];
      mute = (p == 3);
      tick(600);
      cnt = 0;
      for (int k = 0; k < 256; k++) begin
        if (audio === 1'b1) cnt++;
        tick();
      end
      n_checks++;
      if (cnt !== expc[p]) begin n_fail++; $display("FAIL pwm_high p=%0d got %0d exp %0d", p, cnt, expc[p]); end
    end
    mute = 1'b0;
    stop = 3'b111;
    tick();
    stop = 3'b000;
  endtask

  task automatic test_reset_mid;
    int done_seen;
    set_ch(0, 8, 3, 1'b0);
    set_ch(1, 8, 3, 1'b0);
    rom_base[0] = 8'hC0;
    rom_base[1] = 8'hC0;
    trig = 3'b011;
    tick();
    trig = 3'b000;
    tick(10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (rom_addr !== '0) begin n_fail++; $display("FAIL rstmid_addr got %h exp 0", rom_addr); end
    n_checks++; if (busy !== 3'b000) begin n_fail++; $display("FAIL rstmid_busy got %b exp 000", busy); end
    n_checks++; if (done !== 3'b000) begin n_fail++; $display("FAIL rstmid_done got %b exp 000", done); end
    n_checks++; if (audio !== 1'b0) begin n_fail++; $display("FAIL rstmid_audio got %b exp 0", audio); end
    n_checks++; if (mix_sample !== 8'h80) begin n_fail++; $display("FAIL rstmid_mix got %h exp 80", mix_sample); end
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done !== 3'b000 || busy !== 3'b000) done_seen++;
      tick();
    end
    n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL rstmid_quiet got %0d active cycles exp 0", done_seen); end
  endtask

  initial begin
    rst = 1'b1; trig = '0; stop = '0; loop_en = '0; mute = 1'b0;
    rate_div = '0; clip_len = '0;
    for (int i = 0; i < 3; i++) rom_base[i] = 8'h80;
    test_reset();
    test_oneshot();
    test_loop();
    test_trig_stop();
    test_latency();
    test_mix();
    test_pwm();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
